// File: rtl/hash_responder.sv
// hash_responder: bridges an initiator's start/read/force_done protocol to a
// streaming hash core. It fetches NIN input words one at a time, pushes each one
// into the core, then passes NOUT digest words from the core back to the
// initiator until the initiator ends the request with force_done.
//
// Timing:
// - Handshake strobes are registered decodes of the next state, so each strobe
//   is valid for the whole cycle spent in the matching state.
// - The digest path in SQUEEZE is a direct pass-through, gated by state and by
//   the output count.
// - o_core_abort is registered. It rises together with o_hash_force_done_ack, in
//   the cycle after force_done is sampled. It pulses only when force_done arrives
//   before the digest is complete.

module hash_responder #(
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_hash_start,
   input  logic [31:0]           i_hash_input_length,
   input  logic [31:0]           i_hash_output_length,
   output logic [ADDR_WIDTH-1:0] o_hash_addr,
   output logic                  o_hash_rd_en,
   input  logic [31:0]           i_hash_data_in,
   output logic [31:0]           o_hash_data_out,
   output logic                  o_hash_data_out_valid,
   input  logic                  i_hash_data_out_ready,
   input  logic                  i_hash_force_done,
   output logic                  o_hash_force_done_ack,
   output logic                  o_busy,
   output logic                  o_core_start,
   output logic [31:0]           o_core_in_len,
   output logic [31:0]           o_core_out_len,
   output logic [31:0]           o_core_din,
   output logic                  o_core_din_valid,
   output logic                  o_core_din_last,
   input  logic                  i_core_din_ready,
   output logic                  o_core_abort,
   input  logic [31:0]           i_core_dout,
   input  logic                  i_core_dout_valid,
   output logic                  o_core_dout_ready
);

   localparam int unsigned DATA_W = 32;
   // A 32-bit bit count holds at most 2^27 whole words.
   localparam int unsigned CNT_W  = 27;

   typedef enum logic [2:0] {
      IDLE,
      START,
      FETCH,
      CAPTURE,
      PUSH,
      SQUEEZE,
      WAIT_DONE,
      ACK
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]      nin_q, nin_d;
   logic [CNT_W-1:0]      nout_q, nout_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic [CNT_W-1:0]      ocnt_q, ocnt_d;
   logic [DATA_W-1:0]     hold_q, hold_d;
   logic [DATA_W-1:0]     in_len_q, in_len_d;
   logic [DATA_W-1:0]     out_len_q, out_len_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_en_q, rd_en_d;
   logic [DATA_W-1:0]     din_q, din_d;
   logic                  din_valid_q, din_valid_d;
   logic                  din_last_q, din_last_d;
   logic                  start_q, start_d;
   logic                  abort_q, abort_d;
   logic                  ack_q, ack_d;
   logic                  busy_q, busy_d;

   logic                  squeeze_act;
   logic                  out_hs;

   // Number of 32-bit words needed to hold a message of the given bit length.
   function automatic logic [CNT_W-1:0] words_of(input logic [DATA_W-1:0] bits);
      return bits[DATA_W-1:5] + CNT_W'(|bits[4:0]);
   endfunction

   // The digest pass-through is open only while words are still owed.
   always_comb begin
      squeeze_act = (state_q == SQUEEZE) && (ocnt_q < nout_q);
      out_hs      = squeeze_act && i_core_dout_valid && i_hash_data_out_ready;
   end

   // Next-state, counters and next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      nin_d       = nin_q;
      nout_d      = nout_q;
      wcnt_d      = wcnt_q;
      ocnt_d      = ocnt_q;
      hold_d      = hold_q;
      in_len_d    = in_len_q;
      out_len_d   = out_len_q;
      abort_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_hash_start) begin
               in_len_d  = i_hash_input_length;
               out_len_d = i_hash_output_length;
               nin_d     = words_of(i_hash_input_length);
               nout_d    = words_of(i_hash_output_length);
               wcnt_d    = '0;
               ocnt_d    = '0;
               state_d   = START;
            end
         end
         START: begin
            state_d = (nin_q != '0) ? FETCH : SQUEEZE;
         end
         FETCH: begin
            if (i_hash_force_done) begin
               abort_d = 1'b1;
               state_d = ACK;
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (i_hash_force_done) begin
               abort_d = 1'b1;
               state_d = ACK;
            end else begin
               hold_d  = i_hash_data_in;
               state_d = PUSH;
            end
         end
         PUSH: begin
            if (i_hash_force_done) begin
               abort_d = 1'b1;
               state_d = ACK;
            end else if (i_core_din_ready) begin
               wcnt_d  = wcnt_q + CNT_W'(1);
               state_d = (wcnt_q == nin_q - CNT_W'(1)) ? SQUEEZE : FETCH;
            end
         end
         SQUEEZE: begin
            if (i_hash_force_done) begin
               abort_d = 1'b1;
               state_d = ACK;
            end else if (ocnt_q >= nout_q) begin
               state_d = WAIT_DONE;
            end else if (out_hs) begin
               ocnt_d = ocnt_q + CNT_W'(1);
               if (ocnt_q + CNT_W'(1) == nout_q) begin
                  state_d = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (i_hash_force_done) begin
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_en_d     = (state_d == FETCH);
      addr_d      = rd_en_d ? ADDR_WIDTH'(wcnt_d) : '0;
      din_valid_d = (state_d == PUSH);
      din_d       = din_valid_d ? hold_d : '0;
      din_last_d  = din_valid_d && (wcnt_d == nin_q - CNT_W'(1));
      start_d     = (state_d == START);
      ack_d       = (state_d == ACK);
      busy_d      = (state_d != IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         nin_q       <= '0;
         nout_q      <= '0;
         wcnt_q      <= '0;
         ocnt_q      <= '0;
         hold_q      <= '0;
         in_len_q    <= '0;
         out_len_q   <= '0;
         addr_q      <= '0;
         rd_en_q     <= 1'b0;
         din_q       <= '0;
         din_valid_q <= 1'b0;
         din_last_q  <= 1'b0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         nin_q       <= nin_d;
         nout_q      <= nout_d;
         wcnt_q      <= wcnt_d;
         ocnt_q      <= ocnt_d;
         hold_q      <= hold_d;
         in_len_q    <= in_len_d;
         out_len_q   <= out_len_d;
         addr_q      <= addr_d;
         rd_en_q     <= rd_en_d;
         din_q       <= din_d;
         din_valid_q <= din_valid_d;
         din_last_q  <= din_last_d;
         start_q     <= start_d;
         abort_q     <= abort_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
      end
   end

   // Output mapping; digest path passes straight through while squeezing.
   always_comb begin
      o_hash_addr           = addr_q;
      o_hash_rd_en          = rd_en_q;
      o_core_din            = din_q;
      o_core_din_valid      = din_valid_q;
      o_core_din_last       = din_last_q;
      o_core_start          = start_q;
      o_core_abort          = abort_q;
      o_hash_force_done_ack = ack_q;
      o_busy                = busy_q;
      o_core_in_len         = in_len_q;
      o_core_out_len        = out_len_q;
      o_hash_data_out       = squeeze_act ? i_core_dout : '0;
      o_hash_data_out_valid = squeeze_act && i_core_dout_valid;
      o_core_dout_ready     = squeeze_act && i_hash_data_out_ready;
   end

endmodule

// File: tb/tb_hash_responder.sv
// Directed bench for hash_responder: table of length pairs plus hand-written
// sequences for stalls, toggled ready, forced termination and mid-request reset.

module tb_hash_responder;

   localparam int unsigned AW = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_hash_start;
   logic [31:0]   i_hash_input_length;
   logic [31:0]   i_hash_output_length;
   logic [AW-1:0] o_hash_addr;
   logic          o_hash_rd_en;
   logic [31:0]   i_hash_data_in;
   logic [31:0]   o_hash_data_out;
   logic          o_hash_data_out_valid;
   logic          i_hash_data_out_ready;
   logic          i_hash_force_done;
   logic          o_hash_force_done_ack;
   logic          o_busy;
   logic          o_core_start;
   logic [31:0]   o_core_in_len;
   logic [31:0]   o_core_out_len;
   logic [31:0]   o_core_din;
   logic          o_core_din_valid;
   logic          o_core_din_last;
   logic          i_core_din_ready;
   logic          o_core_abort;
   logic [31:0]   i_core_dout;
   logic          i_core_dout_valid;
   logic          o_core_dout_ready;

   hash_responder #(.ADDR_WIDTH(AW)) dut (
      .i_clk                (i_clk),
      .i_rst_n              (i_rst_n),
      .i_hash_start         (i_hash_start),
      .i_hash_input_length  (i_hash_input_length),
      .i_hash_output_length (i_hash_output_length),
      .o_hash_addr          (o_hash_addr),
      .o_hash_rd_en         (o_hash_rd_en),
      .i_hash_data_in       (i_hash_data_in),
      .o_hash_data_out      (o_hash_data_out),
      .o_hash_data_out_valid(o_hash_data_out_valid),
      .i_hash_data_out_ready(i_hash_data_out_ready),
      .i_hash_force_done    (i_hash_force_done),
      .o_hash_force_done_ack(o_hash_force_done_ack),
      .o_busy               (o_busy),
      .o_core_start         (o_core_start),
      .o_core_in_len        (o_core_in_len),
      .o_core_out_len       (o_core_out_len),
      .o_core_din           (o_core_din),
      .o_core_din_valid     (o_core_din_valid),
      .o_core_din_last      (o_core_din_last),
      .i_core_din_ready     (i_core_din_ready),
      .o_core_abort         (o_core_abort),
      .i_core_dout          (i_core_dout),
      .i_core_dout_valid    (i_core_dout_valid),
      .o_core_dout_ready    (o_core_dout_ready)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int in_len;
      int out_len;
      int exp_rd;
      int exp_out;
   } vec_t;

   vec_t        vecs[7];
   logic [31:0] mem[16];

   int n_chk = 0;
   int n_fail = 0;

   int          rd_log[$];
   logic [32:0] din_log[$];
   logic [31:0] out_log[$];
   int n_start, n_abort, n_ack, n_stall;
   int out_idx, acc_cnt;
   int stall_word = -1;
   int stall_left = 0;
   bit toggle_rdy = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] core_word(input int k);
      return 32'hC0DE_0000 + 32'(k);
   endfunction

   task automatic clear_logs();
      rd_log.delete();
      din_log.delete();
      out_log.delete();
      n_start = 0;
      n_abort = 0;
      n_ack   = 0;
      n_stall = 0;
      out_idx = 0;
      acc_cnt = 0;
      i_core_dout = core_word(0);
   endtask

   // One clock: log what happens at the coming edge, then play the initiator
   // memory and the hash core for the next cycle.
   task automatic cycle();
      logic          rd;
      logic [AW-1:0] a;
      logic          ohs;
      logic          dhs;
      @(negedge i_clk);
      rd  = o_hash_rd_en;
      a   = o_hash_addr;
      ohs = o_hash_data_out_valid && i_hash_data_out_ready;
      dhs = o_core_din_valid && i_core_din_ready;
      if (rd) rd_log.push_back(int'(a));
      if (dhs) din_log.push_back({o_core_din_last, o_core_din});
      if (ohs) out_log.push_back(o_hash_data_out);
      if (o_core_start) n_start++;
      if (o_core_abort) n_abort++;
      if (o_hash_force_done_ack) n_ack++;
      if (o_core_din_valid && !i_core_din_ready) begin
         n_stall++;
         check("stall_din", o_core_din, mem[acc_cnt]);
         check("stall_rd_en", 32'(o_hash_rd_en), 32'd0);
      end
      @(posedge i_clk);
      #1;
      i_hash_data_in = rd ? mem[a] : 32'h0BAD_0BAD;
      if (ohs) out_idx++;
      i_core_dout = core_word(out_idx);
      if (dhs) acc_cnt++;
      if (o_core_din_valid && acc_cnt == stall_word && stall_left > 0) begin
         i_core_din_ready = 1'b0;
         stall_left--;
      end else begin
         i_core_din_ready = 1'b1;
      end
      i_hash_data_out_ready = toggle_rdy ? ~i_hash_data_out_ready : 1'b1;
   endtask

   task automatic start_txn(input int in_len, input int out_len, input string tag);
      clear_logs();
      i_hash_input_length  = 32'(in_len);
      i_hash_output_length = 32'(out_len);
      i_hash_start = 1'b1;
      cycle();
      i_hash_start = 1'b0;
      check({tag, " core_start"}, 32'(o_core_start), 32'd1);
      check({tag, " in_len"}, o_core_in_len, 32'(in_len));
      check({tag, " out_len"}, o_core_out_len, 32'(out_len));
   endtask

   // Full request: start, stream all words, verify, then force_done and ack.
   task automatic run_txn(input int in_len, input int out_len, input int exp_rd,
                          input int exp_out, input bit start_in_ack, input string tag);
      int budget;
      start_txn(in_len, out_len, tag);
      budget = 0;
      while ((rd_log.size() < exp_rd || out_log.size() < exp_out) && budget < 400) begin
         cycle();
         budget++;
      end
      check({tag, " timeout"}, 32'(budget < 400), 32'd1);
      repeat (3) cycle();
      check({tag, " reads"}, 32'(rd_log.size()), 32'(exp_rd));
      foreach (rd_log[i]) check({tag, " addr"}, 32'(rd_log[i]), 32'(i));
      check({tag, " words"}, 32'(din_log.size()), 32'(exp_rd));
      foreach (din_log[i]) begin
         check({tag, " din"}, din_log[i][31:0], mem[i]);
         check({tag, " last"}, 32'(din_log[i][32]), 32'(i == exp_rd - 1));
      end
      check({tag, " outs"}, 32'(out_log.size()), 32'(exp_out));
      foreach (out_log[i]) check({tag, " dout"}, out_log[i], core_word(i));
      check({tag, " valid_low"}, 32'(o_hash_data_out_valid), 32'd0);
      check({tag, " dout_ready_low"}, 32'(o_core_dout_ready), 32'd0);
      check({tag, " busy_wait"}, 32'(o_busy), 32'd1);
      check({tag, " n_start"}, 32'(n_start), 32'd1);
      i_hash_force_done = 1'b1;
      cycle();
      i_hash_force_done = 1'b0;
      check({tag, " ack"}, 32'(o_hash_force_done_ack), 32'd1);
      check({tag, " no_abort"}, 32'(o_core_abort), 32'd0);
      if (start_in_ack) i_hash_start = 1'b1;
      cycle();
      i_hash_start = 1'b0;
      check({tag, " ack_end"}, 32'(o_hash_force_done_ack), 32'd0);
      check({tag, " busy_end"}, 32'(o_busy), 32'd0);
      check({tag, " start_end"}, 32'(o_core_start), 32'd0);
      cycle();
      check({tag, " idle"}, 32'(o_busy), 32'd0);
      check({tag, " n_ack"}, 32'(n_ack), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA5C3_0000 + 32'(i * 32'h0101_1011);
      mem[2] = 32'hFEDC_BA98;

      vecs[0] = '{384, 256, 12, 8};
      vecs[1] = '{72,  32,  3,  1};
      vecs[2] = '{1,   1,   1,  1};
      vecs[3] = '{32,  33,  1,  2};
      vecs[4] = '{0,   64,  0,  2};
      vecs[5] = '{64,  0,   2,  0};
      vecs[6] = '{0,   0,   0,  0};

      i_rst_n = 1'b0;
      i_hash_start = 1'b0;
      i_hash_input_length = '0;
      i_hash_output_length = '0;
      i_hash_data_in = '0;
      i_hash_data_out_ready = 1'b1;
      i_hash_force_done = 1'b0;
      i_core_din_ready = 1'b1;
      i_core_dout = '0;
      i_core_dout_valid = 1'b1;
      clear_logs();

      repeat (2) @(posedge i_clk);
      #1;
      check("rst busy", 32'(o_busy), 32'd0);
      check("rst rd_en", 32'(o_hash_rd_en), 32'd0);
      check("rst dout_valid", 32'(o_hash_data_out_valid), 32'd0);
      check("rst in_len", o_core_in_len, 32'd0);
      i_rst_n = 1'b1;
      cycle();

      foreach (vecs[k]) begin
         run_txn(vecs[k].in_len, vecs[k].out_len, vecs[k].exp_rd, vecs[k].exp_out,
                 1'b0, $sformatf("vec%0d", k));
         if (vecs[k].in_len == 72)
            check("w72 top24", 32'(din_log[2][31:8]), 32'h00FE_DCBA);
      end

      // Core stalls word 4 for five cycles.
      stall_word = 4;
      stall_left = 5;
      run_txn(256, 64, 8, 2, 1'b0, "stall");
      check("stall cycles", 32'(n_stall), 32'd5);
      stall_word = -1;

      // Initiator ready toggles every cycle.
      toggle_rdy = 1'b1;
      run_txn(64, 256, 2, 8, 1'b0, "toggle");
      toggle_rdy = 1'b0;
      i_hash_data_out_ready = 1'b1;

      // force_done while word 6 sits in PUSH, core also ready that cycle.
      start_txn(384, 256, "force");
      budget = 0;
      while (!(o_core_din_valid && acc_cnt == 6) && budget < 200) begin
         cycle();
         budget++;
      end
      check("force reach_push6", 32'(budget < 200), 32'd1);
      i_hash_force_done = 1'b1;
      cycle();
      i_hash_force_done = 1'b0;
      check("force ack", 32'(o_hash_force_done_ack), 32'd1);
      check("force abort", 32'(o_core_abort), 32'd1);
      check("force no_rd", 32'(o_hash_rd_en), 32'd0);
      cycle();
      check("force abort_end", 32'(o_core_abort), 32'd0);
      check("force busy_end", 32'(o_busy), 32'd0);
      check("force n_abort", 32'(n_abort), 32'd1);
      check("force n_ack", 32'(n_ack), 32'd1);
      run_txn(96, 64, 3, 2, 1'b0, "after_force");

      // Reset in SQUEEZE abandons the request.
      start_txn(64, 256, "rst_mid");
      budget = 0;
      while (out_log.size() < 2 && budget < 200) begin
         cycle();
         budget++;
      end
      check("rst_mid reach_squeeze", 32'(budget < 200), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid busy", 32'(o_busy), 32'd0);
      check("rst_mid dout_valid", 32'(o_hash_data_out_valid), 32'd0);
      check("rst_mid dout_ready", 32'(o_core_dout_ready), 32'd0);
      check("rst_mid dout", o_hash_data_out, 32'd0);
      check("rst_mid in_len", o_core_in_len, 32'd0);
      check("rst_mid out_len", o_core_out_len, 32'd0);
      check("rst_mid ack", 32'(o_hash_force_done_ack), 32'd0);
      check("rst_mid abort", 32'(o_core_abort), 32'd0);
      n_ack = 0;
      n_abort = 0;
      repeat (2) cycle();
      i_rst_n = 1'b1;
      repeat (2) cycle();
      check("rst_mid n_ack", 32'(n_ack), 32'd0);
      check("rst_mid n_abort", 32'(n_abort), 32'd0);
      check("rst_mid idle", 32'(o_busy), 32'd0);
      run_txn(72, 32, 3, 1, 1'b0, "post_rst");

      // Start raised during ACK must be ignored.
      run_txn(32, 32, 1, 1, 1'b1, "start_in_ack");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
